axi4l_gpio: RTL and testbench

AXI4L_GPIO -- requirements
Module: axi4l_gpio

---
 rtl/axi4l_gpio_if.sv | 66 ++++++
 rtl/axi4l_gpio.sv | 214 +++++++++++++++++++++
 tb/tb_axi4l_gpio.sv | 373 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4l_gpio_if.sv
// AXI4-Lite register-access interface, 32-bit address and data.
//
// Signals
//   aclk, aresetn                     clock/reset mirror, driven by the system clk/rst_n
//   aw*  : awaddr, awvalid, awready   write address channel
//   w*   : wdata, wstrb, wvalid, wready write data channel
//   b*   : bresp, bvalid, bready      write response channel
//   ar*  : araddr, arvalid, arready   read address channel
//   r*   : rdata, rresp, rvalid, rready read data channel
// Modports
//   slave  : register block side
//   master : bus initiator side
interface axi4l_if;
    logic        aclk;
    logic        aresetn;

    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;

    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;

    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;

    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awvalid,
        output awready,
        input  wdata, wstrb, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arvalid,
        output arready,
        output rdata, rresp, rvalid,
        input  rready
    );

    modport master (
        output aclk, aresetn,
        output awaddr, awvalid,
        input  awready,
        output wdata, wstrb, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arvalid,
        input  arready,
        input  rdata, rresp, rvalid,
        output rready
    );
endinterface

// File: rtl/axi4l_gpio.sv
// AXI4-Lite GPIO block with per-pin direction, set/clear aliases and
// rising/falling edge capture into a write-1-to-clear STATUS register.
//
// Parameters
//   N     number of GPIO pins (1..32)
//   SYNC  input synchroniser depth in flops (2..3)
// Ports
//   clk      sole clock, rising edge
//   rst_n    asynchronous active-low reset
//   axi      axi4l_if slave modport, register access
//   gpio_i   pin inputs, asynchronous to clk
//   gpio_o   pin output values (OUT register)
//   gpio_oe  per-pin output enable, 1 = drive (DIR register)
//   irq      level interrupt, OR of STATUS
//
// Register map (offset = addr[11:2] * 4, upper address bits ignored)
//   0x00 OUT RW   0x04 DIR RW      0x08 IN RO       0x0C SET WO
//   0x10 CLR WO   0x14 RISE_EN RW  0x18 FALL_EN RW  0x1C STATUS RW1C
module axi4l_gpio #(
    parameter int N    = 4,
    parameter int SYNC = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    axi4l_if.slave       axi,
    input  logic [N-1:0] gpio_i,
    output logic [N-1:0] gpio_o,
    output logic [N-1:0] gpio_oe,
    output logic         irq
);

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam logic [9:0] OFF_OUT     = 10'd0;
    localparam logic [9:0] OFF_DIR     = 10'd1;
    localparam logic [9:0] OFF_IN      = 10'd2;
    localparam logic [9:0] OFF_SET     = 10'd3;
    localparam logic [9:0] OFF_CLR     = 10'd4;
    localparam logic [9:0] OFF_RISE_EN = 10'd5;
    localparam logic [9:0] OFF_FALL_EN = 10'd6;
    localparam logic [9:0] OFF_STATUS  = 10'd7;

    // Register state
    logic [N-1:0] out_q;
    logic [N-1:0] dir_q;
    logic [N-1:0] rise_en_q;
    logic [N-1:0] fall_en_q;
    logic [N-1:0] status_q;

    // Input synchroniser and edge history
    logic [N-1:0] sync_q [SYNC];
    logic [N-1:0] prev_q;

    // Response channel state
    logic         bvalid_q;
    logic [1:0]   bresp_q;
    logic         rvalid_q;
    logic [31:0]  rdata_q;
    logic [1:0]   rresp_q;

    logic         wr_fire;
    logic         rd_fire;
    logic [9:0]   wr_off;
    logic [9:0]   rd_off;
    logic         wr_mapped;
    logic         rd_mapped;
    logic [31:0]  rd_val;
    logic [31:0]  byte_mask;
    logic [N-1:0] wmask;
    logic [N-1:0] wbits;
    logic [N-1:0] sync_out;
    logic [N-1:0] rise;
    logic [N-1:0] fall;
    logic [N-1:0] edge_set;
    logic [N-1:0] w1c_clr;

    // Handshakes: a write fires when awvalid and wvalid are both high and no
    // B response is pending; awready/wready are asserted only in that cycle.
    // A read fires when arvalid is high and no R response is pending; arready
    // is asserted only in that cycle. bvalid/rvalid rise the cycle after the
    // fire and hold, with resp/data stable, until bready/rready.
    assign wr_fire     = axi.awvalid && axi.wvalid && !bvalid_q;
    assign rd_fire     = axi.arvalid && !rvalid_q;
    assign axi.awready = wr_fire;
    assign axi.wready  = wr_fire;
    assign axi.arready = rd_fire;
    assign axi.bvalid  = bvalid_q;
    assign axi.bresp   = bresp_q;
    assign axi.rvalid  = rvalid_q;
    assign axi.rdata   = rdata_q;
    assign axi.rresp   = rresp_q;

    assign wr_off    = axi.awaddr[11:2];
    assign rd_off    = axi.araddr[11:2];
    assign wr_mapped = (wr_off <= OFF_STATUS);

    assign byte_mask = {{8{axi.wstrb[3]}}, {8{axi.wstrb[2]}},
                        {8{axi.wstrb[1]}}, {8{axi.wstrb[0]}}};
    assign wmask     = byte_mask[N-1:0];
    // Only the strobed bits that exist in the register take part in a write;
    // bits at positions >= N are simply never looked at.
    assign wbits     = axi.wdata[N-1:0] & wmask;

    assign sync_out = sync_q[SYNC-1];
    assign rise     = sync_out & ~prev_q;
    assign fall     = ~sync_out & prev_q;
    assign edge_set = (rise & rise_en_q) | (fall & fall_en_q);
    assign w1c_clr  = (wr_fire && (wr_off == OFF_STATUS)) ? wbits : '0;

    assign gpio_o  = out_q;
    assign gpio_oe = dir_q;
    assign irq     = |status_q;

    // Upper/lower address bits and interface clock/reset mirrors are
    // intentionally ignored.
    logic unused_ok;
    assign unused_ok = ^{axi.aclk, axi.aresetn,
                         axi.awaddr[31:12], axi.awaddr[1:0],
                         axi.araddr[31:12], axi.araddr[1:0], axi.wdata};

    // Writable control registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q     <= '0;
            dir_q     <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
        end else if (wr_fire) begin
            case (wr_off)
                OFF_OUT:     out_q     <= (out_q & ~wmask) | wbits;
                OFF_SET:     out_q     <= out_q | wbits;
                OFF_CLR:     out_q     <= out_q & ~wbits;
                OFF_DIR:     dir_q     <= (dir_q & ~wmask) | wbits;
                OFF_RISE_EN: rise_en_q <= (rise_en_q & ~wmask) | wbits;
                OFF_FALL_EN: fall_en_q <= (fall_en_q & ~wmask) | wbits;
                default: ;
            endcase
        end
    end

    // STATUS: the edge set is applied after the clear so a new edge wins
    // over a W1C landing on the same bit in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            status_q <= '0;
        end else begin
            status_q <= (status_q & ~w1c_clr) | edge_set;
        end
    end

    // Synchroniser chain and previous-value register for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= gpio_i;
            for (int i = 1; i < SYNC; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_out;
        end
    end

    // Read mux uses current register values, so a read in the same cycle as
    // a write to the same register returns the pre-write contents.
    always_comb begin
        rd_val    = '0;
        rd_mapped = 1'b1;
        case (rd_off)
            OFF_OUT:     rd_val = 32'(out_q);
            OFF_DIR:     rd_val = 32'(dir_q);
            OFF_IN:      rd_val = 32'(sync_out);
            OFF_SET:     rd_val = '0;
            OFF_CLR:     rd_val = '0;
            OFF_RISE_EN: rd_val = 32'(rise_en_q);
            OFF_FALL_EN: rd_val = 32'(fall_en_q);
            OFF_STATUS:  rd_val = 32'(status_q);
            default:     rd_mapped = 1'b0;
        endcase
    end

    // Write response channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bvalid_q <= 1'b0;
            bresp_q  <= RESP_OKAY;
        end else if (wr_fire) begin
            bvalid_q <= 1'b1;
            bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (bvalid_q && axi.bready) begin
            bvalid_q <= 1'b0;
        end
    end

    // Read response channel
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else if (rd_fire) begin
            rvalid_q <= 1'b1;
            rdata_q  <= rd_val;
            rresp_q  <= rd_mapped ? RESP_OKAY : RESP_SLVERR;
        end else if (rvalid_q && axi.rready) begin
            rvalid_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4l_gpio.sv
`timescale 1ns/1ps
module tb_axi4l_gpio;

    localparam int N    = 16;
    localparam int SYNC = 2;
    localparam int TMO  = 20;

    localparam logic [31:0] A_OUT     = 32'h00;
    localparam logic [31:0] A_DIR     = 32'h04;
    localparam logic [31:0] A_IN      = 32'h08;
    localparam logic [31:0] A_SET     = 32'h0C;
    localparam logic [31:0] A_CLR     = 32'h10;
    localparam logic [31:0] A_RISE_EN = 32'h14;
    localparam logic [31:0] A_FALL_EN = 32'h18;
    localparam logic [31:0] A_STATUS  = 32'h1C;
    localparam logic [31:0] A_BAD     = 32'h40;

    // ---------------- clock / reset ----------------
    logic         clk    = 1'b0;
    logic         rst_n  = 1'b0;
    logic [N-1:0] gpio_i = '0;
    logic [N-1:0] gpio_o;
    logic [N-1:0] gpio_oe;
    logic         irq;

    always #5 clk = ~clk;

    axi4l_if axi();
    assign axi.aclk    = clk;
    assign axi.aresetn = rst_n;

    axi4l_gpio #(.N(N), .SYNC(SYNC)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .axi     (axi),
        .gpio_i  (gpio_i),
        .gpio_o  (gpio_o),
        .gpio_oe (gpio_oe),
        .irq     (irq)
    );

    // ---------------- scoreboard state ----------------
    int n_cmp = 0;
    int n_bad = 0;
    logic [33:0] exp_q[$];   // {rresp, rdata} expected for each issued read

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [N-1:0] m_out, m_dir, m_rise, m_fall, m_status;
    logic [N-1:0] m_last_set;   // edges captured at the most recent clock edge
    logic [N-1:0] snap_status;  // STATUS as it was just before that edge
    logic [N-1:0] snap_in;      // synchronised input view as seen just before that edge
    logic [N-1:0] hist[$];      // pin value sampled at each clock edge

    function automatic void model_reset();
        m_out = '0; m_dir = '0; m_rise = '0; m_fall = '0; m_status = '0;
        m_last_set = '0; snap_status = '0; snap_in = '0;
        hist = {};
        for (int i = 0; i < SYNC + 1; i++) hist.push_back('0);
    endfunction

    // A pin value sampled at an edge becomes visible SYNC edges later; an edge
    // between two consecutive visible values is captured one edge after that.
    always @(posedge clk) begin : edge_model
        int last;
        logic [N-1:0] cur, old, r, f;
        if (rst_n) begin
            snap_status = m_status;
            hist.push_back(gpio_i);
            last = hist.size() - 1;
            cur = hist[last - SYNC];
            old = hist[last - SYNC - 1];
            snap_in = cur;
            r = cur & ~old;
            f = ~cur & old;
            m_last_set = (r & m_rise) | (f & m_fall);
            m_status = m_status | m_last_set;
            if (hist.size() > SYNC + 2) void'(hist.pop_front());
        end
    end

    function automatic logic [1:0] exp_bresp(input logic [31:0] addr);
        return (addr[11:2] < 10'd8) ? 2'b00 : 2'b10;
    endfunction

    function automatic void model_write(input logic [31:0] addr, input logic [31:0] data,
                                        input logic [3:0] strb);
        logic [31:0] m32, d32;
        logic [N-1:0] m, d;
        m32 = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        d32 = data & m32;
        m = m32[N-1:0];
        d = d32[N-1:0];
        case (addr[11:2])
            10'd0: m_out  = (m_out & ~m) | d;
            10'd1: m_dir  = (m_dir & ~m) | d;
            10'd3: m_out  = m_out | d;
            10'd4: m_out  = m_out & ~d;
            10'd5: m_rise = (m_rise & ~m) | d;
            10'd6: m_fall = (m_fall & ~m) | d;
            10'd7: m_status = m_status & ~(d & ~m_last_set);
            default: ;
        endcase
    endfunction

    function automatic logic [33:0] model_read(input logic [31:0] addr);
        case (addr[11:2])
            10'd0: return {2'b00, 32'(m_out)};
            10'd1: return {2'b00, 32'(m_dir)};
            10'd2: return {2'b00, 32'(snap_in)};
            10'd3: return {2'b00, 32'h0};
            10'd4: return {2'b00, 32'h0};
            10'd5: return {2'b00, 32'(m_rise)};
            10'd6: return {2'b00, 32'(m_fall)};
            10'd7: return {2'b00, 32'(snap_status)};
            default: return {2'b10, 32'h0};
        endcase
    endfunction

    // ---------------- per-cycle output compare ----------------
    always @(negedge clk) begin
        check("gpio_o", 64'(gpio_o), 64'(m_out));
        check("gpio_oe", 64'(gpio_oe), 64'(m_dir));
        check("irq", 64'(irq), 64'(|m_status));
    end

    // ---------------- driver tasks (called just after a negedge) ----------------
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        int t;
        axi.awaddr  = addr;
        axi.wdata   = data;
        axi.wstrb   = strb;
        axi.awvalid = 1'b1;
        axi.wvalid  = 1'b1;
        axi.bready  = 1'b1;
        #1;
        t = 0;
        while (!axi.awready && t < TMO) begin @(negedge clk); #1; t++; end
        check("aw_accept", 64'(axi.awready), 64'd1);
        @(posedge clk); #1;
        model_write(addr, data, strb);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b0;
        t = 0;
        while (!axi.bvalid && t < TMO) begin @(posedge clk); #1; t++; end
        check("bvalid", 64'(axi.bvalid), 64'd1);
        resp = axi.bresp;
        check("bresp", 64'(resp), 64'(exp_bresp(addr)));
        @(negedge clk);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] data,
                            output logic [1:0] resp);
        int t;
        logic [33:0] e;
        axi.araddr  = addr;
        axi.arvalid = 1'b1;
        axi.rready  = 1'b1;
        #1;
        t = 0;
        while (!axi.arready && t < TMO) begin @(negedge clk); #1; t++; end
        check("ar_accept", 64'(axi.arready), 64'd1);
        @(posedge clk); #1;
        exp_q.push_back(model_read(addr));
        axi.arvalid = 1'b0;
        t = 0;
        while (!axi.rvalid && t < TMO) begin @(posedge clk); #1; t++; end
        check("rvalid", 64'(axi.rvalid), 64'd1);
        data = axi.rdata;
        resp = axi.rresp;
        e = exp_q.pop_front();
        check("rdata_rresp", 64'({resp, data}), 64'(e));
        @(negedge clk);
    endtask

    task automatic wr(input logic [31:0] addr, input logic [31:0] data);
        logic [1:0] r;
        axi_write(addr, data, 4'hF, r);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin : main
        logic [31:0] d;
        logic [1:0]  r;
        int t;

        axi.awaddr = '0; axi.awvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
        axi.wvalid = 1'b0; axi.bready = 1'b1; axi.araddr = '0; axi.arvalid = 1'b0;
        axi.rready = 1'b1;
        model_reset();

        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        // Reset values
        check("rst_gpio_o", 64'(gpio_o), 64'h0);
        check("rst_gpio_oe", 64'(gpio_oe), 64'h0);
        check("rst_irq", 64'(irq), 64'h0);
        check("rst_bvalid", 64'(axi.bvalid), 64'h0);
        check("rst_rvalid", 64'(axi.rvalid), 64'h0);
        @(negedge clk);
        axi_read(A_STATUS, d, r);
        check("rst_status", 64'(d), 64'h0);

        // OUT / DIR / SET / CLR
        wr(A_OUT, 32'h5);
        wr(A_DIR, 32'hF);
        wr(A_SET, 32'h2);
        check("set_gpio_o", 64'(gpio_o), 64'h7);
        wr(A_CLR, 32'h4);
        check("clr_gpio_o", 64'(gpio_o), 64'h3);
        check("dir_gpio_oe", 64'(gpio_oe), 64'hF);
        axi_read(A_SET, d, r);
        check("set_reads_0", 64'(d), 64'h0);
        axi_read(A_CLR, d, r);
        check("clr_reads_0", 64'(d), 64'h0);

        // Bits above N read as zero; upper address bits alias
        wr(A_DIR, 32'hFFFF_FFFF);
        axi_read(A_DIR, d, r);
        check("dir_upper_bits", 64'(d), 64'h0000_FFFF);
        wr(A_DIR, 32'hF);
        axi_read(32'h0000_3000 | A_OUT, d, r);
        check("alias_out", 64'(d), 64'h3);

        // Rising edge capture and W1C
        wr(A_RISE_EN, 32'h1);
        gpio_i[0] = 1'b1;
        repeat (SYNC) @(negedge clk);
        check("rise_irq_early", 64'(irq), 64'h0);
        @(negedge clk);
        check("rise_irq", 64'(irq), 64'h1);
        axi_read(A_STATUS, d, r);
        check("rise_status", 64'(d), 64'h1);
        axi_read(A_IN, d, r);
        check("in_value", 64'(d), 64'h1);
        wr(A_STATUS, 32'h1);
        check("w1c_irq", 64'(irq), 64'h0);

        // Enabling FALL_EN after a fall must not capture it
        gpio_i[0] = 1'b0;
        repeat (5) @(negedge clk);
        wr(A_FALL_EN, 32'h1);
        repeat (3) @(negedge clk);
        check("no_retro_irq", 64'(irq), 64'h0);

        // W1C landing in the same cycle as a new enabled edge
        gpio_i[0] = 1'b1;
        repeat (SYNC) @(negedge clk);
        wr(A_STATUS, 32'h1);
        check("w1c_vs_edge_irq", 64'(irq), 64'h1);
        axi_read(A_STATUS, d, r);
        check("w1c_vs_edge_status", 64'(d), 64'h1);
        wr(A_STATUS, 32'h1);
        check("w1c2_irq", 64'(irq), 64'h0);

        // Falling edge capture
        gpio_i[0] = 1'b0;
        repeat (SYNC + 2) @(negedge clk);
        check("fall_irq", 64'(irq), 64'h1);
        wr(A_STATUS, 32'h1);

        // Multi-pin edges and byte-masked W1C
        wr(A_RISE_EN, 32'hFFFF);
        wr(A_FALL_EN, 32'h00FF);
        gpio_i = 16'hA5C3;
        repeat (5) @(negedge clk);
        axi_read(A_STATUS, d, r);
        check("multi_rise_status", 64'(d), 64'hA5C3);
        axi_write(A_STATUS, 32'hFFFF_FFFF, 4'b0001, r);
        axi_read(A_STATUS, d, r);
        check("w1c_strb_status", 64'(d), 64'hA500);
        gpio_i = 16'h0F0F;
        repeat (5) @(negedge clk);
        axi_read(A_STATUS, d, r);
        check("multi_edge_status", 64'(d), 64'hAFCC);
        axi_read(A_IN, d, r);
        check("multi_in", 64'(d), 64'h0F0F);
        wr(A_STATUS, 32'hFFFF_FFFF);
        check("multi_clear_irq", 64'(irq), 64'h0);

        // Unmapped offset
        axi_read(A_BAD, d, r);
        check("bad_rresp", 64'(r), 64'h2);
        check("bad_rdata", 64'(d), 64'h0);
        axi_write(A_BAD, 32'hFF, 4'hF, r);
        check("bad_bresp", 64'(r), 64'h2);
        axi_read(A_OUT, d, r);
        check("bad_out_kept", 64'(d), 64'h3);
        axi_read(A_DIR, d, r);
        axi_read(A_RISE_EN, d, r);
        axi_read(A_FALL_EN, d, r);

        // Byte strobe on OUT
        axi_write(A_OUT, 32'hFFFF_FFFF, 4'b0001, r);
        axi_read(A_OUT, d, r);
        check("strb_out", 64'(d), 64'h00FF);

        // B channel back-pressure: response held, no second write accepted
        axi.awaddr = A_DIR; axi.wdata = 32'hAAAA; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
        #1;
        t = 0;
        while (!axi.awready && t < TMO) begin @(negedge clk); #1; t++; end
        check("hold_accept", 64'(axi.awready), 64'd1);
        @(posedge clk); #1;
        model_write(A_DIR, 32'hAAAA, 4'hF);
        axi.awaddr = A_OUT; axi.wdata = 32'h1234;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_bvalid", 64'(axi.bvalid), 64'h1);
            check("hold_no_accept", 64'(axi.awready), 64'h0);
        end
        axi.awvalid = 1'b0; axi.wvalid = 1'b0; axi.bready = 1'b1;
        @(posedge clk); #1;
        check("hold_bvalid_drop", 64'(axi.bvalid), 64'h0);
        @(negedge clk);
        check("hold_gpio_oe", 64'(gpio_oe), 64'hAAAA);

        // Reset while a B response is pending
        wr(A_OUT, 32'h00F0);
        gpio_i = 16'h0000;
        repeat (5) @(negedge clk);
        check("pre_rst_irq", 64'(irq), 64'h1);
        axi.awaddr = A_DIR; axi.wdata = 32'h5555; axi.wstrb = 4'hF;
        axi.awvalid = 1'b1; axi.wvalid = 1'b1; axi.bready = 1'b0;
        #1;
        t = 0;
        while (!axi.awready && t < TMO) begin @(negedge clk); #1; t++; end
        @(posedge clk); #1;
        model_write(A_DIR, 32'h5555, 4'hF);
        axi.awvalid = 1'b0; axi.wvalid = 1'b0;
        @(negedge clk);
        check("pre_rst_bvalid", 64'(axi.bvalid), 64'h1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("rst_async_bvalid", 64'(axi.bvalid), 64'h0);
        check("rst_async_gpio_o", 64'(gpio_o), 64'h0);
        check("rst_async_gpio_oe", 64'(gpio_oe), 64'h0);
        check("rst_async_irq", 64'(irq), 64'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        axi.bready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("post_rst_bvalid", 64'(axi.bvalid), 64'h0);
            check("post_rst_rvalid", 64'(axi.rvalid), 64'h0);
        end
        axi_read(A_OUT, d, r);
        check("post_rst_out", 64'(d), 64'h0);

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

endmodule
